// File: rtl/lights_seq.sv
// lights_seq: multi-channel LED colour sequencer with hold/step/auto modes.
// Optional LIGHTS_SYNC_EN adds a 2-flop button synchroniser per channel.
//
// Ports:
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   button  per-channel button level
//   mode    00 HOLD, 01 STEP, 10 AUTO, 11 FREEZE
//   dir     0 = count up, 1 = count down
//   colour  registered colour codes, channel i at [i*WIDTH +: WIDTH]
//   wrap    registered one-cycle pulse when a channel wraps
module lights_seq #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 3,
    parameter int FIRST    = 1,
    parameter int LAST     = 6,
    parameter int PRESCALE = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       button,
    input  logic [1:0]                mode,
    input  logic                      dir,
    output logic [CHANNELS*WIDTH-1:0] colour,
    output logic [CHANNELS-1:0]       wrap
);

    typedef enum logic [1:0] {
        HOLD   = 2'b00,
        STEP   = 2'b01,
        AUTO   = 2'b10,
        FREEZE = 2'b11
    } mode_t;

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    P_MAX   = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] C_FIRST = WIDTH'(FIRST);
    localparam logic [WIDTH-1:0] C_LAST  = WIDTH'(LAST);

    mode_t               mode_e;
    logic [PW-1:0]       cnt;
    logic                tick;
    logic [CHANNELS-1:0] btn;
    logic [CHANNELS-1:0] btn_q;
    logic [CHANNELS-1:0] adv;
    logic [WIDTH-1:0]    col_q [CHANNELS];
    logic [WIDTH-1:0]    col_d [CHANNELS];
    logic [CHANNELS-1:0] wrap_d;

    assign mode_e = mode_t'(mode);

    // With PRESCALE=1 the counter is stuck at 0 and tick is always high.
    assign tick = (cnt == P_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

`ifdef LIGHTS_SYNC_EN
    logic [CHANNELS-1:0] sync1;
    logic [CHANNELS-1:0] sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
        end
    end

    assign btn = sync2;
`else
    assign btn = button;
`endif

    // Previous button level, tracked in every mode so that entering
    // STEP with a button already held does not count as a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q <= '0;
        end else begin
            btn_q <= btn;
        end
    end

    always_comb begin
        adv = '0;
        unique case (mode_e)
            HOLD:    adv = {CHANNELS{tick}} & btn;
            STEP:    adv = btn & ~btn_q;
            AUTO:    adv = {CHANNELS{tick}} & ~btn;
            FREEZE:  adv = '0;
            default: adv = '0;
        endcase
    end

    // Out-of-range codes are scrubbed back to FIRST before anything else.
    always_comb begin
        wrap_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            col_d[i] = col_q[i];
            if (col_q[i] < C_FIRST || col_q[i] > C_LAST) begin
                col_d[i] = C_FIRST;
            end else if (adv[i] && !dir) begin
                if (col_q[i] == C_LAST) begin
                    col_d[i]  = C_FIRST;
                    wrap_d[i] = 1'b1;
                end else begin
                    col_d[i] = col_q[i] + 1'b1;
                end
            end else if (adv[i] && dir) begin
                if (col_q[i] == C_FIRST) begin
                    col_d[i]  = C_LAST;
                    wrap_d[i] = 1'b1;
                end else begin
                    col_d[i] = col_q[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                col_q[i] <= C_FIRST;
            end
            wrap <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                col_q[i] <= col_d[i];
            end
            wrap <= wrap_d;
        end
    end

    always_comb begin
        colour = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            colour[i*WIDTH +: WIDTH] = col_q[i];
        end
    end

endmodule
